// File: rtl/q_meter.sv
// Edge-count meter: counts rising edges of an asynchronous input over fixed gate windows,
// averages 2^AVG_LOG2 windows and publishes the result after i_ref has been stable.
module q_meter #(
  parameter int unsigned BUS_WIDTH     = 10,
  parameter int unsigned GATE_CYCLES   = 1024,
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned AVG_LOG2      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 sig_in,
  input  logic [BUS_WIDTH-1:0] i_ref,
  output logic [BUS_WIDTH-1:0] q_measured,
  output logic                 ready,
  output logic                 busy,
  output logic                 overflow
);

  localparam int unsigned GW      = $clog2(GATE_CYCLES);
  localparam int unsigned SW      = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned IW      = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned AW      = BUS_WIDTH + AVG_LOG2;
  localparam int unsigned NUM_WIN = 1 << AVG_LOG2;

  typedef enum logic [1:0] {StIdle, StSettle, StGate, StDone} state_e;

  state_e               state_q, state_d;
  logic                 sync1_q, sync2_q, hist_q;
  logic [BUS_WIDTH-1:0] i_ref_q;
  logic [SW-1:0]        settle_cnt_q, settle_cnt_d;
  logic [GW-1:0]        gate_cnt_q, gate_cnt_d;
  logic [IW-1:0]        win_idx_q, win_idx_d;
  logic [BUS_WIDTH-1:0] win_cnt_q, win_cnt_d;
  logic [AW-1:0]        acc_q, acc_d;
  logic                 sat_q, sat_d;
  logic [BUS_WIDTH-1:0] q_meas_q, q_meas_d;
  logic                 ready_q, ready_d;
  logic                 ovf_q, ovf_d;

  logic                 sig_rise, iref_chg, win_full, sat_hit, last_gate, last_win;
  logic [BUS_WIDTH-1:0] win_inc;
  logic [AW-1:0]        acc_sum;

  assign sig_rise  = sync2_q & ~hist_q;
  assign iref_chg  = (i_ref != i_ref_q);
  assign win_full  = &win_cnt_q;
  assign sat_hit   = sig_rise & win_full;
  assign win_inc   = (sig_rise && !win_full) ? win_cnt_q + 1'b1 : win_cnt_q;
  // Sum includes an edge landing on the last gate cycle.
  assign acc_sum   = acc_q + AW'(win_inc);
  assign last_gate = (gate_cnt_q == GW'(GATE_CYCLES - 1));
  assign last_win  = (win_idx_q == IW'(NUM_WIN - 1));

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    gate_cnt_d   = gate_cnt_q;
    win_idx_d    = win_idx_q;
    win_cnt_d    = win_cnt_q;
    acc_d        = acc_q;
    sat_d        = sat_q;
    q_meas_d     = q_meas_q;
    ready_d      = 1'b0;
    ovf_d        = ovf_q;
    if (!enable) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d      = StSettle;
          settle_cnt_d = '0;
        end
        StSettle: begin
          if (iref_chg) begin
            settle_cnt_d = '0;
          end else if (settle_cnt_q == SW'(SETTLE_CYCLES - 1)) begin
            state_d    = StGate;
            gate_cnt_d = '0;
            win_idx_d  = '0;
            win_cnt_d  = '0;
            acc_d      = '0;
            sat_d      = 1'b0;
          end else begin
            settle_cnt_d = settle_cnt_q + 1'b1;
          end
        end
        StGate: begin
          if (iref_chg) begin
            state_d      = StSettle;
            settle_cnt_d = '0;
          end else begin
            sat_d = sat_q | sat_hit;
            if (last_gate) begin
              acc_d      = acc_sum;
              win_cnt_d  = '0;
              gate_cnt_d = '0;
              if (last_win) begin
                // Publish on entry to DONE so the result is valid alongside ready.
                state_d  = StDone;
                ready_d  = 1'b1;
                q_meas_d = BUS_WIDTH'(acc_sum >> AVG_LOG2);
                ovf_d    = sat_q | sat_hit;
              end else begin
                win_idx_d = win_idx_q + 1'b1;
              end
            end else begin
              gate_cnt_d = gate_cnt_q + 1'b1;
              win_cnt_d  = win_inc;
            end
          end
        end
        StDone: begin
          state_d      = StSettle;
          settle_cnt_d = '0;
          sat_d        = 1'b0;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      hist_q       <= 1'b0;
      i_ref_q      <= '0;
      settle_cnt_q <= '0;
      gate_cnt_q   <= '0;
      win_idx_q    <= '0;
      win_cnt_q    <= '0;
      acc_q        <= '0;
      sat_q        <= 1'b0;
      q_meas_q     <= '0;
      ready_q      <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sig_in;
      sync2_q      <= sync1_q;
      hist_q       <= sync2_q;
      i_ref_q      <= i_ref;
      settle_cnt_q <= settle_cnt_d;
      gate_cnt_q   <= gate_cnt_d;
      win_idx_q    <= win_idx_d;
      win_cnt_q    <= win_cnt_d;
      acc_q        <= acc_d;
      sat_q        <= sat_d;
      q_meas_q     <= q_meas_d;
      ready_q      <= ready_d;
      ovf_q        <= ovf_d;
    end
  end

  assign q_measured = q_meas_q;
  assign ready      = ready_q;
  assign overflow   = ovf_q;
  assign busy       = (state_q != StIdle);

endmodule
